// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero mask output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int AW = 4 * DIGITS;

  // 10^DIGITS >= 2^BIN_W  <=>  DIGITS*log2(10) >= BIN_W, log2(10) scaled by 1e6
  if (BIN_W < 1 ||
      (longint'(DIGITS) * 64'sd3321928) < (longint'(BIN_W) * 64'sd1000000)) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS too small for BIN_W, or BIN_W < 1");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [BIN_W-1:0] sh_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_corr;
  logic [AW-1:0]    acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    bcd_q;

  // Digits >= 5 become <= 12 after +3, so per-nibble arithmetic never carries.
  always_comb begin
    acc_corr = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_corr[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
    acc_d = {acc_corr[AW-2:0], sh_q[BIN_W-1]};
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_above;

  // A digit blanks only when it and every higher digit are zero; ones digit never blanks.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (acc_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  assign blank = blank_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q    <= bin_in;
            acc_q   <= '0;
            cnt_q   <= CW'(BIN_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= acc_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= blank_d;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq (8/3 and 12/4)
// Blank-mask checks are compiled in when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a;
  logic [11:0] bin_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [11:0] bcd_a;
  logic [15:0] bcd_b;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank_a;
  logic [3:0]  blank_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank_a)
`endif
  );

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, packed one nibble per digit.
  function automatic logic [15:0] ref_bcd(input int v, input int dg);
    logic [15:0] r = '0;
    for (int i = 0; i < dg; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(input int v, input int dg);
    logic [3:0] r = '0;
    int p = 10;
    for (int i = 1; i < dg; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion from the current (idle or done) cycle and waits for done.
  // glitch_mask bit n re-asserts start with 42 at the n-th sample of the conversion.
  task automatic run(input bit sel, input int v, input int glitch_mask);
    int lat = 0;
    int busy_n = 0;
    int w  = sel ? 12 : 8;
    int dg = sel ? 4 : 3;
    logic [15:0] got;
    if (sel) begin start_b = 1'b1; bin_b = 12'(v); end
    else     begin start_a = 1'b1; bin_a = 8'(v); end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    while (!(sel ? done_b : done_a) && lat < 40) begin
      if (sel ? busy_b : busy_a) busy_n++;
      if (lat < 32 && glitch_mask[lat]) begin
        if (sel) begin start_b = 1'b1; bin_b = 12'd42; end
        else     begin start_a = 1'b1; bin_a = 8'd42; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      tick();
      lat++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    got = sel ? bcd_b : {4'h0, bcd_a};
    check("latency", lat, w);
    check("busy_cycles", busy_n, w);
    check("busy_at_done", sel ? busy_b : busy_a, 1'b0);
    check("bcd", got, ref_bcd(v, dg));
`ifdef BIN2BCD_BLANK_EN
    check("blank", sel ? {28'h0, blank_b} : {29'h0, blank_a}, ref_blank(v, dg));
`endif
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done_a) cnt++;
    end
  endtask

  initial begin
    int dn;
    int v;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    tick(); tick();
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bcd", bcd_a, 12'h000);
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank", blank_a, 3'b000);
`endif
    rst = 1'b0;
    tick();

    run(1'b0, 255, 0);
    tick();
    run(1'b0, 0, 0);
    tick();
    run(1'b0, 7, 0);
    tick();

    run(1'b1, 4095, 0);
    tick();
    run(1'b1, 1000, 0);
    tick();
    run(1'b1, 999, 0);
    tick();

    // start pulses while busy must be ignored
    run(1'b0, 100, (1 << 3) | (1 << 7));
    count_dones(12, dn);
    check("no_second_done", dn, 0);
    check("bcd_held", bcd_a, 12'h100);

    // reset mid-conversion aborts without a done
    run(1'b0, 59, 0);
    tick();
    start_a = 1'b1; bin_a = 8'd200;
    tick();
    start_a = 1'b0;
    count_dones(3, dn);
    rst = 1'b1;
    tick();
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_bcd", bcd_a, 12'h000);
`ifdef BIN2BCD_BLANK_EN
    check("abort_blank", blank_a, 3'b000);
`endif
    rst = 1'b0;
    begin
      int dn2;
      count_dones(12, dn2);
      check("abort_no_done", dn + dn2, 0);
    end
    run(1'b0, 13, 0);
    tick();

    // back-to-back: second start issued in the done cycle
    run(1'b0, 128, 0);
    run(1'b0, 64, 0);

    // exhaustive sweep, back-to-back with occasional random gaps
    for (int i = 0; i < 256; i++) begin
      run(1'b0, i, 0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 4095));
      run(1'b1, v, 0);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It replaces the single-cycle unrolled converter in the display path: the counter or timekeeping logic hands it a binary value with a start pulse, and the 7-segment digit driver consumes the packed BCD result on a one-cycle done strobe. Arbitrary input widths are supported without a long combinational chain.

## Interface
- BIN_W, default 8: binary input width, minimum 1.
- DIGITS, default 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1. This is checked by an elaboration-time assertion.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only when the block is idle.
- bin_in  in  BIN_W  unsigned binary value; captured on the accepted start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle strobe; bcd_out is updated in the same cycle.
- bcd_out  out  4*DIGITS  packed result; digit i occupies bits [4i+3:4i], digit 0 is the ones digit.
- blank  out  DIGITS  leading-zero mask. Present only with BIN2BCD_BLANK_EN.

## Operation
- States: IDLE and SHIFT.
- Internal registers:
  - sh: BIN_W-bit shift register.
  - acc: 4*DIGITS-bit working accumulator.
  - cnt: bit counter, width clog2(BIN_W+1).
- IDLE, start=1:
  - sh ← bin_in, acc ← 0, cnt ← BIN_W.
  - busy ← 1; go to SHIFT.
- IDLE, start=0: hold all registers.
- SHIFT, each cycle:
  - Every digit of acc that is ≥5 gets +3, computed combinationally from the current acc.
  - The corrected value is shifted left by 1, with sh[BIN_W−1] entering acc bit 0.
  - sh shifts left by 1, zero-filled.
  - cnt decrements.
- SHIFT, when cnt=1 (final bit):
  - The shifted result is written directly to bcd_out.
  - done ← 1, busy ← 0; go to IDLE.
- Digit correction uses 4-bit arithmetic. A digit ≥5 becomes ≤12 after +3, so no carry is produced into the next digit before the shift.
- bcd_out holds its last result until the next completion. It never shows partial values.
- start while busy=1 is ignored: no queueing, no restart. bin_in is don't-care after capture.
- Each bcd_out digit is always in 0..9 for legal parameter sets.

## Timing
- Reset, applied at any rising edge with rst=1:
  - state IDLE; busy=0, done=0, bcd_out=0, sh=0, acc=0, cnt=0, blank=0.
  - Any conversion in progress is aborted and no done is issued.
- Start accepted at edge k:
  - busy=1 after edge k.
  - Shifts occur at edges k+1 … k+BIN_W.
  - After edge k+BIN_W: done=1, busy=0, bcd_out valid.
  - Latency from start to done is BIN_W cycles. Throughput is one conversion per BIN_W+1 cycles maximum.
- done is high for exactly one cycle. The state is already IDLE during that cycle, so a start in the done cycle is accepted: back-to-back operation with a 1-cycle gap.
- busy and done are never high together.
- BIN_W=1: single SHIFT cycle; done appears after edge k+1.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - blank is a registered output, updated together with bcd_out.
  - blank[i]=1 iff digit i and all higher digits are zero, for i ≥ 1.
  - blank[0] is always 0, so a value of 0 displays as a single "0".
- BIN2BCD_BLANK_EN undefined: the blank port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults (8/3). start with bin_in=255 → done exactly 8 cycles after start; bcd_out=12'h255; busy high for 8 cycles. With EN: blank=3'b000.
- Defaults. bin_in=0 → bcd_out=12'h000. With EN: blank=3'b110. Then bin_in=7 → bcd_out=12'h007, blank=3'b110.
- BIN_W=12, DIGITS=4. Values 4095, 1000, 999 → 16'h4095, 16'h1000, 16'h0999, each 12 cycles after its start.
- Defaults. start with bin_in=100; pulse start with bin_in=42 at cycles 3 and 7 of the conversion → single done, bcd_out=12'h100, no second done.
- Defaults. Convert 59 (→12'h059). Start 200, then assert rst at cycle 4 of that conversion → done never asserts; all outputs 0 after the reset edge. A subsequent start with 13 → 12'h013.
- Defaults. start asserted in the done cycle of a conversion of 128 with bin_in=64 → first bcd_out=12'h128, second done 8 cycles later with 12'h064. Exhaustive sweep 0..255 against a reference model.
